// File: rtl/axis_rx_check_module.sv
// axis_rx_check_module
//   Receive-side frame checker for the 100G CMAC RX user interface. Beats are
//   byte-reordered so wire byte 0 lands in [511:504], then compared against
//   the TX generator's test-frame format: header beat, marker beat, counter
//   beats. Emits a per-frame pass/fail pulse and keeps saturating counters.
//
//   Optional feature (macro RX_CHECK_STICKY_EN): adds i_err_clr, o_err_sticky
//   and o_err_beat, which capture the index of the first failing beat.
//
// Ports
//   i_clk, i_rst_n     MAC RX user clock, async active-low reset
//   i_stat_rx_status   CMAC RX aligned; beats are ignored while low
//   s_axis_rx_*        512-bit RX stream (no tready), tuser = MAC error on tlast
//   o_frame_done       one-cycle pulse per checked frame
//   o_frame_ok         frame result, valid with o_frame_done
//   o_good_cnt         passed frames, saturating
//   o_err_cnt          failed frames, saturating
//   o_checker_busy     a frame is in progress
module axis_rx_check_module #(
  parameter int unsigned P_FRAME_LEN = 10,
  parameter logic [47:0] P_DST_MAC   = 48'hff_ff_ff_ff_ff_ff,
  parameter logic [47:0] P_SRC_MAC   = 48'h01_02_03_04_05_06,
  parameter logic [15:0] P_TYPE      = 16'h0800,
  parameter int unsigned P_CNT_W     = 32
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_stat_rx_status,
  input  logic               s_axis_rx_tvalid,
  input  logic [511:0]       s_axis_rx_tdata,
  input  logic               s_axis_rx_tlast,
  input  logic [63:0]        s_axis_rx_tkeep,
  input  logic               s_axis_rx_tuser,
`ifdef RX_CHECK_STICKY_EN
  input  logic               i_err_clr,
  output logic               o_err_sticky,
  output logic [15:0]        o_err_beat,
`endif
  output logic               o_frame_done,
  output logic               o_frame_ok,
  output logic [P_CNT_W-1:0] o_good_cnt,
  output logic [P_CNT_W-1:0] o_err_cnt,
  output logic               o_checker_busy
);

  localparam logic [15:0]  LAST_IDX = 16'(P_FRAME_LEN - 1);
  localparam logic [511:0] HDR_BEAT = {P_DST_MAC, P_SRC_MAC, P_TYPE, {50{8'hab}}};
  localparam logic [511:0] MRK_BEAT = {32{16'haabb}};

  typedef enum logic [1:0] {ST_IDLE, ST_BODY, ST_DROP} state_t;

  // ---------------- stage 1: register + reorder ----------------
  logic [511:0] rev_data;
  logic [63:0]  rev_keep;

  always_comb begin
    rev_data = '0;
    rev_keep = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      rev_data[(63-i)*8 +: 8] = s_axis_rx_tdata[i*8 +: 8];
      rev_keep[63-i]          = s_axis_rx_tkeep[i];
    end
  end

  logic         s1_valid, s1_last, s1_user, s1_status;
  logic [511:0] s1_data;
  logic [63:0]  s1_keep;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s1_user   <= 1'b0;
      s1_status <= 1'b0;
      s1_data   <= '0;
      s1_keep   <= '0;
    end else begin
      s1_valid  <= s_axis_rx_tvalid;
      s1_last   <= s_axis_rx_tlast;
      s1_user   <= s_axis_rx_tuser;
      s1_status <= i_stat_rx_status;
      s1_data   <= rev_data;
      s1_keep   <= rev_keep;
    end
  end

  // ---------------- stage 2: compare + FSM ----------------
  state_t      state, state_n;
  logic [15:0] beat_idx, beat_idx_n;
  logic        err_flag, err_flag_n;
  logic        done_n, ok_n;
  logic [15:0] cnt_val;
  logic [511:0] exp_beat;
  logic        beat_bad;

  // beat_idx stays 0 in IDLE, so the same compare covers beat 0 there.
  always_comb begin
    cnt_val = beat_idx - 16'd1;
    if (beat_idx == 16'd0)      exp_beat = HDR_BEAT;
    else if (beat_idx == 16'd1) exp_beat = MRK_BEAT;
    else                        exp_beat = {32{cnt_val}};
  end

  assign beat_bad = (s1_data != exp_beat) || (s1_keep != '1) ||
                    (s1_last && s1_user) ||
                    (s1_last ? (beat_idx != LAST_IDX) : (beat_idx == LAST_IDX));

  always_comb begin
    state_n    = state;
    beat_idx_n = beat_idx;
    err_flag_n = err_flag;
    done_n     = 1'b0;
    ok_n       = 1'b0;
    if (!s1_status) begin
      state_n    = ST_IDLE;
      beat_idx_n = '0;
      err_flag_n = 1'b0;
    end else if (s1_valid) begin
      unique case (state)
        ST_IDLE: begin
          if (s1_last) begin
            done_n = 1'b1;
          end else begin
            state_n    = ST_BODY;
            beat_idx_n = 16'd1;
            err_flag_n = beat_bad;
          end
        end
        ST_BODY: begin
          if (s1_last) begin
            done_n     = 1'b1;
            ok_n       = ~(err_flag | beat_bad);
            state_n    = ST_IDLE;
            beat_idx_n = '0;
            err_flag_n = 1'b0;
          end else begin
            beat_idx_n = beat_idx + 16'd1;
            err_flag_n = err_flag | beat_bad;
            if (beat_idx == LAST_IDX) state_n = ST_DROP;
          end
        end
        ST_DROP: begin
          if (s1_last) begin
            done_n     = 1'b1;
            state_n    = ST_IDLE;
            beat_idx_n = '0;
            err_flag_n = 1'b0;
          end
        end
        default: begin
          state_n    = ST_IDLE;
          beat_idx_n = '0;
          err_flag_n = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= ST_IDLE;
      beat_idx     <= '0;
      err_flag     <= 1'b0;
      o_frame_done <= 1'b0;
      o_frame_ok   <= 1'b0;
      o_good_cnt   <= '0;
      o_err_cnt    <= '0;
    end else begin
      state        <= state_n;
      beat_idx     <= beat_idx_n;
      err_flag     <= err_flag_n;
      o_frame_done <= done_n;
      o_frame_ok   <= ok_n;
      if (done_n) begin
        if (ok_n) begin
          if (o_good_cnt != '1) o_good_cnt <= o_good_cnt + P_CNT_W'(1);
        end else begin
          if (o_err_cnt != '1) o_err_cnt <= o_err_cnt + P_CNT_W'(1);
        end
      end
    end
  end

  assign o_checker_busy = (state != ST_IDLE);

`ifdef RX_CHECK_STICKY_EN
  // Beats discarded in DROP are not candidates; the failure was already
  // attributed to the last-index beat that lacked tlast.
  logic err_hit;
  assign err_hit = s1_status && s1_valid && (state != ST_DROP) && beat_bad;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_err_sticky <= 1'b0;
      o_err_beat   <= '0;
    end else if (i_err_clr) begin
      o_err_sticky <= 1'b0;
      o_err_beat   <= '0;
    end else if (err_hit && !o_err_sticky) begin
      o_err_sticky <= 1'b1;
      o_err_beat   <= beat_idx;
    end
  end
`endif

endmodule
